// File: rtl/beam_power_trigger_v4.sv
// beam_power_trigger_v4: per-beam sum-of-squares power compared against two double-buffered threshold sets.
// Define BEAM_POWER_TRIG_SCALER_EN to build the per-beam set-0 trigger scalers.
module beam_power_trigger_v4 #(
  parameter int NBEAMS = 48,
  parameter int NSAMP = 8,
  parameter int BEAM_BITS = 9,
  parameter int HOLDOFF = 4,
  localparam int PWR_BITS = 2*BEAM_BITS + $clog2(NSAMP),
  localparam int SEL_W = NBEAMS > 1 ? $clog2(NBEAMS) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NBEAMS*NSAMP*BEAM_BITS-1:0] beams_i,
  input  logic [2*PWR_BITS-1:0]             thresh_i,
  input  logic [1:0]                        thresh_wr_i,
  input  logic [1:0]                        thresh_update_i,
  input  logic [NBEAMS-1:0]                 mask_i,
  output logic [2*NBEAMS-1:0]               trigger_o,
  input  logic [SEL_W-1:0]                  scaler_sel_i,
  input  logic                              scaler_clr_i,
  output logic [15:0]                       scaler_o
);
  localparam int SQ_BITS = 2*BEAM_BITS;
  localparam int HO_BITS = HOLDOFF > 0 ? $clog2(HOLDOFF+1) : 1;
  logic signed [SQ_BITS-1:0] smp [NBEAMS*NSAMP];
  logic [SQ_BITS-1:0] sq_q [NBEAMS*NSAMP], sq_d [NBEAMS*NSAMP];
  logic [PWR_BITS-1:0] pwr_q [NBEAMS], pwr_d [NBEAMS];
  logic [PWR_BITS-1:0] pend_q [2][NBEAMS], pend_d [2][NBEAMS];
  logic [PWR_BITS-1:0] act_q [2][NBEAMS], act_d [2][NBEAMS];
  logic [HO_BITS-1:0] hold_q [2][NBEAMS], hold_d [2][NBEAMS];
  logic [2*NBEAMS-1:0] trigger_q, trigger_d;
  assign trigger_o = trigger_q;
  always_comb begin
    trigger_d = '0;
    pend_d = pend_q;
    act_d = act_q;
    hold_d = hold_q;
    for (int i = 0; i < NBEAMS*NSAMP; i++) begin
      smp[i] = SQ_BITS'($signed(beams_i[i*BEAM_BITS +: BEAM_BITS]));
      sq_d[i] = smp[i] * smp[i];
    end
    for (int b = 0; b < NBEAMS; b++) begin
      pwr_d[b] = '0;
      for (int s = 0; s < NSAMP; s++) pwr_d[b] = pwr_d[b] + PWR_BITS'(sq_q[b*NSAMP+s]);
    end
    for (int k = 0; k < 2; k++) begin
      // update copies the pre-shift pending contents even when a write lands on the same clock
      if (thresh_update_i[k]) act_d[k] = pend_q[k];
      if (thresh_wr_i[k]) begin
        for (int b = 0; b < NBEAMS-1; b++) pend_d[k][b] = pend_q[k][b+1];
        pend_d[k][NBEAMS-1] = thresh_i[k*PWR_BITS +: PWR_BITS];
      end
      for (int b = 0; b < NBEAMS; b++) begin
        trigger_d[k*NBEAMS+b] = pwr_q[b] > act_q[k][b] && !mask_i[b] && hold_q[k][b] == '0;
        hold_d[k][b] = trigger_d[k*NBEAMS+b] ? HO_BITS'(HOLDOFF) :
                       hold_q[k][b] != '0 ? hold_q[k][b] - HO_BITS'(1) : '0;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sq_q <= '{default: '0};
      pwr_q <= '{default: '0};
      trigger_q <= '0;
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < NBEAMS; b++) begin
          pend_q[k][b] <= '1;
          act_q[k][b] <= '1;
          hold_q[k][b] <= '0;
        end
    end else begin
      sq_q <= sq_d;
      pwr_q <= pwr_d;
      trigger_q <= trigger_d;
      pend_q <= pend_d;
      act_q <= act_d;
      hold_q <= hold_d;
    end
  end
`ifdef BEAM_POWER_TRIG_SCALER_EN
  logic [15:0] cnt_q [NBEAMS], cnt_d [NBEAMS];
  logic [15:0] scaler_q, scaler_d;
  always_comb begin
    for (int b = 0; b < NBEAMS; b++)
      cnt_d[b] = scaler_clr_i ? '0 :
                 trigger_q[b] && cnt_q[b] != 16'hffff ? cnt_q[b] + 16'd1 : cnt_q[b];
    scaler_d = int'(scaler_sel_i) < NBEAMS ? cnt_q[scaler_sel_i] : '0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '{default: '0};
      scaler_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      scaler_q <= scaler_d;
    end
  end
  assign scaler_o = scaler_q;
`else
  logic unused_scaler;
  assign unused_scaler = ^{scaler_sel_i, scaler_clr_i};
  assign scaler_o = '0;
`endif
endmodule

// File: tb/tb_beam_power_trigger_v4.sv
// tb_beam_power_trigger_v4: directed bench for beam_power_trigger_v4, NBEAMS=4, with HOLDOFF=4 and HOLDOFF=0 instances.
module tb_beam_power_trigger_v4;
  localparam logic [20:0] MAX = '1;
  logic clk, rst_n, clr;
  logic [287:0] beams;
  logic [41:0] thresh;
  logic [1:0] wr, upd, sel;
  logic [3:0] mask;
  logic [7:0] trig_a, trig_b;
  logic [15:0] scl_a, scl_b;
  int pass = 0, total = 0;

  beam_power_trigger_v4 #(.NBEAMS(4), .NSAMP(8), .BEAM_BITS(9), .HOLDOFF(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .beams_i(beams), .thresh_i(thresh), .thresh_wr_i(wr),
    .thresh_update_i(upd), .mask_i(mask), .trigger_o(trig_a), .scaler_sel_i(sel),
    .scaler_clr_i(clr), .scaler_o(scl_a));
  beam_power_trigger_v4 #(.NBEAMS(4), .NSAMP(8), .BEAM_BITS(9), .HOLDOFF(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .beams_i(beams), .thresh_i(thresh), .thresh_wr_i(wr),
    .thresh_update_i(upd), .mask_i(mask), .trigger_o(trig_b), .scaler_sel_i(sel),
    .scaler_clr_i(clr), .scaler_o(scl_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_beam(input int b, input logic [8:0] v);
    for (int s = 0; s < 8; s++) beams[(b*8+s)*9 +: 9] = v;
  endtask
  task automatic wr_thr(input int k, input logic [20:0] v);
    thresh[k*21 +: 21] = v;
    wr[k] = 1'b1;
    tick(1);
    wr[k] = 1'b0;
  endtask
  task automatic load4(input int k, input logic [20:0] w0, w1, w2, w3);
    wr_thr(k, w0); wr_thr(k, w1); wr_thr(k, w2); wr_thr(k, w3);
  endtask
  task automatic update(input int k);
    upd[k] = 1'b1;
    tick(1);
    upd[k] = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    total++; if (trig_a !== 8'h00) $display("FAIL reset_trig_a got %h exp 00", trig_a); else pass++;
    total++; if (trig_b !== 8'h00) $display("FAIL reset_trig_b got %h exp 00", trig_b); else pass++;
    total++; if (scl_a !== 16'h0) $display("FAIL reset_scl_a got %h exp 0000", scl_a); else pass++;
    total++; if (scl_b !== 16'h0) $display("FAIL reset_scl_b got %h exp 0000", scl_b); else pass++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_latency;
    beams = '0;
    load4(0, MAX, 21'd799, MAX, MAX);
    update(0);
    tick(3);
    set_beam(1, 9'd10);
    tick(2);
    total++; if (trig_a !== 8'h00) $display("FAIL lat_early got %h exp 00", trig_a); else pass++;
    tick(1);
    total++; if (trig_a !== 8'h02) $display("FAIL lat_a got %h exp 02", trig_a); else pass++;
    total++; if (trig_b !== 8'h02) $display("FAIL lat_b got %h exp 02", trig_b); else pass++;
    tick(1);
    total++; if (trig_a !== 8'h00) $display("FAIL lat_hold_a got %h exp 00", trig_a); else pass++;
    total++; if (trig_b !== 8'h02) $display("FAIL lat_next_b got %h exp 02", trig_b); else pass++;
    load4(0, MAX, 21'd800, MAX, MAX);
    update(0);
    repeat (4) begin
      tick(1);
      total++; if (trig_b !== 8'h00) $display("FAIL equal_b got %h exp 00", trig_b); else pass++;
      total++; if (trig_a !== 8'h00) $display("FAIL equal_a got %h exp 00", trig_a); else pass++;
    end
  endtask

  task automatic test_overflow;
    beams = '0;
    set_beam(0, 9'h100);
    load4(0, 21'd0, 21'd0, 21'd0, 21'd0);
    load4(1, 21'd0, 21'd0, 21'd0, 21'd0);
    update(0);
    update(1);
    tick(3);
    total++; if (trig_b !== 8'h11) $display("FAIL overflow_b got %h exp 11", trig_b); else pass++;
  endtask

  task automatic test_holdoff;
    logic [7:0] ea, eb;
    beams = '0;
    load4(0, MAX, 21'd799, MAX, MAX);
    load4(1, MAX, MAX, MAX, MAX);
    update(0);
    update(1);
    tick(4);
    set_beam(1, 9'd10);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      ea = (k >= 3 && (k - 3) % 5 == 0) ? 8'h02 : 8'h00;
      eb = k >= 3 ? 8'h02 : 8'h00;
      total++; if (trig_a !== ea) $display("FAIL holdoff4 k=%0d got %h exp %h", k, trig_a, ea); else pass++;
      total++; if (trig_b !== eb) $display("FAIL holdoff0 k=%0d got %h exp %h", k, trig_b, eb); else pass++;
    end
    mask = 4'b0010;
    repeat (6) begin
      tick(1);
      total++; if (trig_a !== 8'h00) $display("FAIL mask_a got %h exp 00", trig_a); else pass++;
      total++; if (trig_b !== 8'h00) $display("FAIL mask_b got %h exp 00", trig_b); else pass++;
    end
    mask = 4'b0000;
    tick(1);
    total++; if (trig_a !== 8'h02) $display("FAIL unmask_a got %h exp 02", trig_a); else pass++;
    total++; if (trig_b !== 8'h02) $display("FAIL unmask_b got %h exp 02", trig_b); else pass++;
  endtask

  task automatic test_thresh_load;
    set_beam(0, 9'd4);
    set_beam(1, 9'd5);
    set_beam(2, 9'd7);
    set_beam(3, 9'd7);
    load4(0, MAX, MAX, MAX, MAX);
    update(0);
    load4(1, 21'd100, 21'd200, 21'd300, 21'd400);
    tick(2);
    total++; if (trig_b !== 8'h00) $display("FAIL pending_only got %h exp 00", trig_b); else pass++;
    update(1);
    total++; if (trig_b !== 8'h00) $display("FAIL update_same got %h exp 00", trig_b); else pass++;
    tick(1);
    total++; if (trig_b !== 8'h50) $display("FAIL update_b got %h exp 50", trig_b); else pass++;
    total++; if (trig_a !== 8'h50) $display("FAIL update_a got %h exp 50", trig_a); else pass++;
    load4(1, MAX, MAX, MAX, MAX);
    thresh[21 +: 21] = 21'd0;
    wr = 2'b10;
    upd = 2'b10;
    tick(1);
    wr = 2'b00;
    upd = 2'b00;
    tick(1);
    total++; if (trig_b !== 8'h00) $display("FAIL wr_upd_preshift got %h exp 00", trig_b); else pass++;
    update(1);
    tick(1);
    total++; if (trig_b !== 8'h80) $display("FAIL post_shift got %h exp 80", trig_b); else pass++;
  endtask

  task automatic test_reset_mid;
    load4(0, 21'd0, 21'd0, 21'd0, 21'd0);
    update(0);
    tick(1);
    total++; if (trig_b !== 8'h8f) $display("FAIL stream_b got %h exp 8f", trig_b); else pass++;
    rst_n = 1'b0;
    #1;
    total++; if (trig_a !== 8'h00) $display("FAIL rst_async_a got %h exp 00", trig_a); else pass++;
    total++; if (trig_b !== 8'h00) $display("FAIL rst_async_b got %h exp 00", trig_b); else pass++;
    tick(1);
    rst_n = 1'b1;
    repeat (6) begin
      tick(1);
      total++; if (trig_a !== 8'h00) $display("FAIL rst_residual_a got %h exp 00", trig_a); else pass++;
      total++; if (trig_b !== 8'h00) $display("FAIL rst_residual_b got %h exp 00", trig_b); else pass++;
    end
  endtask

  task automatic test_scaler;
    load4(0, MAX, MAX, 21'd0, MAX);
    update(0);
    sel = 2'd2;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
`ifdef BEAM_POWER_TRIG_SCALER_EN
    tick(70000);
    total++; if (scl_b !== 16'hffff) $display("FAIL scaler_sat got %h exp ffff", scl_b); else pass++;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    total++; if (scl_b !== 16'h0000) $display("FAIL scaler_clr got %h exp 0000", scl_b); else pass++;
    tick(1);
    total++; if (scl_b !== 16'h0001) $display("FAIL scaler_restart got %h exp 0001", scl_b); else pass++;
`else
    tick(10);
    total++; if (trig_b !== 8'h04) $display("FAIL scaler_stream got %h exp 04", trig_b); else pass++;
    total++; if (scl_b !== 16'h0000) $display("FAIL scaler_tied_b got %h exp 0000", scl_b); else pass++;
    total++; if (scl_a !== 16'h0000) $display("FAIL scaler_tied_a got %h exp 0000", scl_a); else pass++;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    beams = '0;
    thresh = '0;
    wr = '0;
    upd = '0;
    mask = '0;
    sel = '0;
    clr = 1'b0;
    test_reset;
    test_latency;
    test_overflow;
    test_holdoff;
    test_thresh_load;
    test_reset_mid;
    test_scaler;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
